// File: rtl/maze_ctrl.sv
// maze_ctrl: sequencing FSM for the maze-walker datapath.
//
// Runs a depth-first search over a 16x16 maze memory. The datapath holds the
// current {x,y} location, a +/-1 adder producing the candidate neighbour
// (nxtLoc) and a location stack. This block steers that datapath, marks
// visited cells in the maze memory, and reports done (goal reached) or fail
// (stack exhausted with no unexplored neighbour).
//
// Optional feature: define MAZE_CTRL_STEP_CNT_EN to add a 16-bit saturating
// "steps" output counting forward moves plus backtracking pops.

module maze_ctrl #(
  parameter logic [7:0] GOAL = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cntReach,
  input  logic        empStck,
  input  logic [7:0]  curLoc,
  input  logic [7:0]  nxtLoc,
  input  logic        memDout,
  output logic        dpRst,
  output logic        rgLd,
  output logic [1:0]  dir,
  output logic        push,
  output logic        pop,
  output logic        adderEn,
  output logic [7:0]  memAdr,
  output logic        memRdEn,
  output logic        memWr,
  output logic        done,
  output logic        fail,
  output logic        busy
`ifdef MAZE_CTRL_STEP_CNT_EN
  ,
  output logic [15:0] steps
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_MOVE  = 3'd4;
  localparam logic [2:0] S_BACK  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_FAIL  = 3'd7;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] dir_nxt;

  // "Advance direction" outcome, shared by CHECK (boundary) and READ (blocked).
  logic [2:0] adv_state;
  logic [1:0] adv_dir;

  // Try the next direction, or backtrack once all four have been tried.
  always_comb begin
    if (dir == 2'b11) begin
      adv_state = S_BACK;
      adv_dir   = dir;
    end else begin
      adv_state = S_CHECK;
      adv_dir   = dir + 2'd1;
    end
  end

  // State and direction registers; reset aborts any search in progress.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state <= S_IDLE;
      dir   <= 2'b00;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
    end
  end

  // Next-state logic and per-state datapath / memory controls.
  always_comb begin
    // NOTE: every output and next-value gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_nxt = state;
    dir_nxt   = dir;
    dpRst     = 1'b0;
    rgLd      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    adderEn   = 1'b0;
    memAdr    = 8'h00;
    memRdEn   = 1'b0;
    memWr     = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_INIT;
      end

      // Clear the datapath (location back to 00) and mark the start cell.
      S_INIT: begin
        dpRst     = 1'b1;
        memAdr    = 8'h00;
        memWr     = 1'b1;
        dir_nxt   = 2'b00;
        state_nxt = S_CHECK;
      end

      // Goal test, then either skip a wrapping direction or read the cell.
      S_CHECK: begin
        if (curLoc == GOAL) begin
          state_nxt = S_DONE;
        end else if (cntReach) begin
          state_nxt = adv_state;
          dir_nxt   = adv_dir;
        end else begin
          adderEn   = 1'b1;
          memAdr    = nxtLoc;
          memRdEn   = 1'b1;
          state_nxt = S_READ;
        end
      end

      // Read data arrives this cycle; keep the address stable.
      S_READ: begin
        adderEn = 1'b1;
        memAdr  = nxtLoc;
        if (!memDout) begin
          state_nxt = S_MOVE;
        end else begin
          state_nxt = adv_state;
          dir_nxt   = adv_dir;
        end
      end

      // Step forward: push the old cell, load and mark the new one together.
      S_MOVE: begin
        adderEn   = 1'b1;
        push      = 1'b1;
        rgLd      = 1'b1;
        memWr     = 1'b1;
        memAdr    = nxtLoc;
        dir_nxt   = 2'b00;
        state_nxt = S_CHECK;
      end

      // Dead end: pop back to the previous cell and rescan it from dir 00.
      S_BACK: begin
        if (empStck) begin
          state_nxt = S_FAIL;
        end else begin
          pop       = 1'b1;
          rgLd      = 1'b1;
          dir_nxt   = 2'b00;
          state_nxt = S_CHECK;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_INIT;
      end

      S_FAIL: begin
        fail = 1'b1;
        if (start) state_nxt = S_INIT;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Busy covers every searching state.
  always_comb begin
    busy = !((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
  end

`ifdef MAZE_CTRL_STEP_CNT_EN
  logic step_evt;

  // A step is a forward move or a successful backtrack pop.
  always_comb begin
    step_evt = (state == S_MOVE) || ((state == S_BACK) && !empStck);
  end

  // Saturating step counter, cleared at the start of each run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      steps <= 16'h0000;
    end else if (state == S_INIT) begin
      steps <= 16'h0000;
    end else if (step_evt && (steps != 16'hFFFF)) begin
      steps <= steps + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maze_ctrl.sv
// tb_maze_ctrl: self-checking bench for maze_ctrl.
//
// Surrounds the controller with a behavioural datapath (location registers,
// adder, stack) and a 256x1 maze memory with 1-cycle read latency. A
// queue-based DFS reference model predicts, for each maze, the outcome, the
// number of cycles from INIT to DONE/FAIL, push/pop counts, the final
// visited-mark map and (with MAZE_CTRL_STEP_CNT_EN) the step count.

module tb_maze_ctrl;

  localparam logic [7:0] GOAL    = 8'h20;
  localparam int         MAX_CYC = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cntReach;
  logic        empStck;
  logic [7:0]  curLoc;
  logic [7:0]  nxtLoc;
  logic        memDout;
  logic        dpRst, rgLd, push, pop, adderEn, memRdEn, memWr;
  logic        done, fail, busy;
  logic [1:0]  dir;
  logic [7:0]  memAdr;
`ifdef MAZE_CTRL_STEP_CNT_EN
  logic [15:0] steps;
`endif

  int n_checks = 0;
  int n_errors = 0;

  maze_ctrl #(.GOAL(GOAL)) dut (
    .clk(clk), .rst(rst), .start(start), .cntReach(cntReach),
    .empStck(empStck), .curLoc(curLoc), .nxtLoc(nxtLoc), .memDout(memDout),
    .dpRst(dpRst), .rgLd(rgLd), .dir(dir), .push(push), .pop(pop),
    .adderEn(adderEn), .memAdr(memAdr), .memRdEn(memRdEn), .memWr(memWr),
    .done(done), .fail(fail), .busy(busy)
`ifdef MAZE_CTRL_STEP_CNT_EN
    , .steps(steps)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- environment: datapath + maze memory ----------------
  logic [3:0] cx = 4'd0;
  logic [3:0] cy = 4'd0;
  logic [7:0] stk [256];
  int         sp = 0;
  int         nx_i, ny_i;
  bit         mem [256];
  bit         maze_init [256];
  bit         model_mem [256];
  bit         load_mem = 1'b0;
  bit         clr_cnt = 1'b0;
  logic       rd_q = 1'b0;
  int         n_push = 0;
  int         n_pop = 0;
  int         n_bad = 0;

  assign curLoc  = {cx, cy};
  assign empStck = (sp == 0);
  assign memDout = rd_q;

  always_comb begin
    nx_i = int'(cx);
    ny_i = int'(cy);
    case (dir)
      2'b00:   ny_i = ny_i - 1;
      2'b01:   nx_i = nx_i + 1;
      2'b10:   nx_i = nx_i - 1;
      default: ny_i = ny_i + 1;
    endcase
    cntReach = (nx_i < 0) || (nx_i > 15) || (ny_i < 0) || (ny_i > 15);
    if (pop && (sp > 0)) nxtLoc = stk[sp-1];
    else                 nxtLoc = {nx_i[3:0], ny_i[3:0]};
  end

  always @(posedge clk) begin
    if (dpRst) begin
      cx <= 4'd0;
      cy <= 4'd0;
      sp <= 0;
    end else begin
      if (rgLd) {cx, cy} <= nxtLoc;
      if (push) begin
        stk[sp] <= curLoc;
        sp      <= sp + 1;
      end
      if (pop && (sp > 0)) sp <= sp - 1;
    end
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= maze_init[i];
    end else if (memWr) begin
      mem[memAdr] <= 1'b1;
    end
    if (memRdEn) rd_q <= mem[memAdr];
  end

  always @(posedge clk) begin
    if (clr_cnt) begin
      n_push <= 0;
      n_pop  <= 0;
      n_bad  <= 0;
    end else begin
      if (push) n_push <= n_push + 1;
      if (pop)  n_pop  <= n_pop + 1;
      if ((push && pop) || (pop && empStck) || (memWr && memRdEn)) n_bad <= n_bad + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DFS over maze_init: cycles counted from INIT entry to terminal state.
  task automatic ref_model(output int cyc, output bit ok, output int moves, output int pops);
    int x, y, nx, ny, d;
    bit moved;
    logic [7:0] v;
    logic [7:0] stack [$];
    for (int i = 0; i < 256; i++) model_mem[i] = maze_init[i];
    model_mem[0] = 1'b1;
    x = 0; y = 0; cyc = 1; moves = 0; pops = 0; ok = 1'b0;
    forever begin
      if (x * 16 + y == int'(GOAL)) begin
        cyc += 1;
        ok = 1'b1;
        break;
      end
      moved = 1'b0;
      d = 0;
      while (!moved && d < 4) begin
        nx = x; ny = y;
        case (d)
          0:       ny = y - 1;
          1:       nx = x + 1;
          2:       nx = x - 1;
          default: ny = y + 1;
        endcase
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
          cyc += 1;
        end else if (model_mem[nx * 16 + ny]) begin
          cyc += 2;
        end else begin
          cyc += 3;
          stack.push_back(8'(x * 16 + y));
          model_mem[nx * 16 + ny] = 1'b1;
          x = nx; y = ny;
          moved = 1'b1;
          moves++;
        end
        d++;
      end
      if (!moved) begin
        cyc += 1;
        if (stack.size() == 0) break;
        pops++;
        v = stack.pop_back();
        x = int'(v[7:4]);
        y = int'(v[3:0]);
      end
    end
  endtask

  task automatic fill_maze(input bit val);
    for (int i = 0; i < 256; i++) maze_init[i] = val;
  endtask

  task automatic load_env();
    load_mem = 1'b1;
    clr_cnt  = 1'b1;
    tick();
    load_mem = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  // Run one search on maze_init and compare everything against the model.
  task automatic run_search(input string tag, input bit glitch);
    int exp_cyc, exp_moves, exp_pops, n, bad_mem;
    bit exp_ok, fin;
    ref_model(exp_cyc, exp_ok, exp_moves, exp_pops);
    load_env();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ":init_dprst"}, 32'(dpRst), 32'd1);
    check({tag, ":init_status"}, 32'({done, fail}), 32'd0);
    n = 0;
    fin = 1'b0;
    while (!fin && n < MAX_CYC) begin
      tick();
      n++;
      if (n == 1) begin
        check({tag, ":dprst_single"}, 32'(dpRst), 32'd0);
`ifdef MAZE_CTRL_STEP_CNT_EN
        check({tag, ":steps_cleared"}, 32'(steps), 32'd0);
`endif
      end
      start = (glitch && n == 1);
      if (done || fail) fin = 1'b1;
    end
    start = 1'b0;
    check({tag, ":finished"}, 32'(fin), 32'd1);
    check({tag, ":cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, ":outcome"}, 32'({done, fail}), exp_ok ? 32'd2 : 32'd1);
    check({tag, ":pushes"}, 32'(n_push), 32'(exp_moves));
    check({tag, ":pops"}, 32'(n_pop), 32'(exp_pops));
    check({tag, ":protocol"}, 32'(n_bad), 32'd0);
    bad_mem = 0;
    for (int i = 0; i < 256; i++) if (mem[i] != model_mem[i]) bad_mem++;
    check({tag, ":visited_map"}, 32'(bad_mem), 32'd0);
    if (exp_ok) check({tag, ":goal_loc"}, 32'(curLoc), 32'(GOAL));
`ifdef MAZE_CTRL_STEP_CNT_EN
    check({tag, ":steps"}, 32'(steps), 32'(exp_moves + exp_pops));
`endif
    repeat (2) tick();
    check({tag, ":hold"}, 32'({done, fail, busy}), exp_ok ? 32'd4 : 32'd2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    #2 rst = 1'b0;
    repeat (2) tick();
    check("reset_outputs",
          32'({dpRst, rgLd, dir, push, pop, adderEn, memAdr, memRdEn, memWr, done, fail, busy}),
          32'd0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Blocked start: both in-range neighbours of 00 are walls.
    fill_maze(1'b0);
    maze_init[8'h10] = 1'b1;
    maze_init[8'h01] = 1'b1;
    run_search("blocked", 1'b0);

    // Straight corridor to 20 with a stray start pulse during the first CHECK.
    fill_maze(1'b0);
    run_search("corridor", 1'b1);
    // Restart from DONE on the same maze.
    run_search("restart", 1'b0);

    // Dead end: only 00, 10, 11 open.
    fill_maze(1'b1);
    maze_init[8'h00] = 1'b0;
    maze_init[8'h10] = 1'b0;
    maze_init[8'h11] = 1'b0;
    run_search("deadend", 1'b0);
    // Steps must clear on the following run as well.
    run_search("deadend_again", 1'b0);

    // Asynchronous reset mid-READ.
    fill_maze(1'b0);
    load_env();
    start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (memRdEn) seen = 1'b1;
    end
    check("rst_reach_check_read", 32'(seen), 32'd1);
    tick();
    check("rst_in_read", 32'({adderEn, memRdEn, busy}), 32'b101);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_read",
          32'({dpRst, rgLd, dir, push, pop, adderEn, memAdr, memRdEn, memWr, done, fail, busy}),
          32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();
    check("rst_stays_idle", 32'({busy, done, fail, dpRst}), 32'd0);
    run_search("after_reset", 1'b0);

    // Random mazes, roughly 30% walls.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++) maze_init[i] = ($urandom_range(99) < 30);
      run_search($sformatf("random%0d", k), k[0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
